// File: rtl/gem_csc_lut_pkg.sv
// Shared constants and types for the writable GEM-CSC slope-correction LUT.
// Table index is {isME1a, even, layer}; entry address is {table, bend}.
package gem_csc_lut_pkg;

  localparam int MXADRB     = 4;
  localparam int MXDATB     = 8;
  localparam int MXTBLB     = 3;
  localparam int LUT_ADRB   = MXTBLB + MXADRB;
  localparam int LUT_DEPTH  = 128;
  localparam int N_RD_PORTS = 5;

  localparam int TBL_LAYER_POS = 0;
  localparam int TBL_EVEN_POS  = 1;
  localparam int TBL_ME1A_POS  = 2;

  localparam logic [LUT_ADRB-1:0] LAST_ADR = LUT_ADRB'(LUT_DEPTH - 1);

  // GEM layer 1 is "A", layer 2 is "B".
  typedef enum logic {
    LAYER_A = 1'b0,
    LAYER_B = 1'b1
  } gem_layer_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } lut_state_t;

  function automatic logic [LUT_ADRB-1:0] lut_adr(
    input logic              me1a,
    input logic              even,
    input gem_layer_t        layer,
    input logic [MXADRB-1:0] bend
  );
    logic [MXTBLB-1:0] tbl;
    tbl                = '0;
    tbl[TBL_ME1A_POS]  = me1a;
    tbl[TBL_EVEN_POS]  = even;
    tbl[TBL_LAYER_POS] = layer;
    return {tbl, bend};
  endfunction

endpackage

// File: rtl/gem_csc_lut_ram.sv
// 128x8 flop array: one synchronous write port, five asynchronous read ports.
// Contents are not reset; the owner clears them with an init sweep.
module gem_csc_lut_ram
  import gem_csc_lut_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 we,
  input  logic [LUT_ADRB-1:0]                  wr_adr,
  input  logic [MXDATB-1:0]                    wr_dat,
  input  logic [N_RD_PORTS-1:0][LUT_ADRB-1:0]  rd_adr,
  output logic [N_RD_PORTS-1:0][MXDATB-1:0]    rd_dat
);

  logic [MXDATB-1:0] mem [LUT_DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_adr] <= wr_dat;
  end

  generate
    for (genvar gi = 0; gi < N_RD_PORTS; gi++) begin : g_rd
      assign rd_dat[gi] = mem[rd_adr[gi]];
    end
  endgenerate

endmodule

// File: rtl/gem_csc_slope_lut_writer.sv
// Writable GEM-CSC slope-correction LUT: init sweep FSM, auto-incrementing
// VME-style load/readback pointer, and four registered CLCT-to-GEM offsets.
module gem_csc_slope_lut_writer
  import gem_csc_lut_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                ptr_load,
  input  logic [LUT_ADRB-1:0] ptr_adr,
  input  logic                wr_strobe,
  input  logic [MXDATB-1:0]   wr_data,
  output logic [MXDATB-1:0]   rd_data,
  output logic [LUT_ADRB-1:0] ptr,
  output logic                ptr_wrapped,
  output logic                wr_err,
  output logic                lut_ready,
  input  logic [MXADRB-1:0]   clct0_bend,
  input  logic [MXADRB-1:0]   clct1_bend,
  input  logic                isME1a0,
  input  logic                isME1a1,
  input  logic                even,
  output logic [MXDATB-1:0]   clct0_gemA_offset,
  output logic [MXDATB-1:0]   clct0_gemB_offset,
  output logic [MXDATB-1:0]   clct1_gemA_offset,
  output logic [MXDATB-1:0]   clct1_gemB_offset
);

  localparam int N_LOOKUP = 4;
  localparam int RB_PORT  = 4;

  lut_state_t                            state, state_next;
  logic [LUT_ADRB-1:0]                   init_adr;
  logic                                  ram_we;
  logic [LUT_ADRB-1:0]                   ram_wr_adr;
  logic [MXDATB-1:0]                     ram_wr_dat;
  logic [N_RD_PORTS-1:0][LUT_ADRB-1:0]   rd_adr;
  logic [N_RD_PORTS-1:0][MXDATB-1:0]     rd_dat;
  logic [N_LOOKUP-1:0][MXDATB-1:0]       offset;
  logic [LUT_ADRB-1:0]                   wr_base;

  // A same-cycle ptr_load redirects the write to the freshly loaded address.
  assign wr_base = ptr_load ? ptr_adr : ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_adr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_adr <= init_adr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_wr_adr = wr_base;
    ram_wr_dat = wr_data;
    case (state)
      INIT: begin
        ram_we     = 1'b1;
        ram_wr_adr = init_adr;
        ram_wr_dat = '0;
        if (init_adr == LAST_ADR) state_next = READY;
      end
      READY: begin
        ram_we = wr_strobe && lut_ready;
      end
      default: state_next = INIT;
    endcase
  end

  // lut_ready trails the state by one clock so it rises on the 129th edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lut_ready <= 1'b0;
    end else begin
      lut_ready <= (state == READY);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      ptr_wrapped <= 1'b0;
      wr_err      <= 1'b0;
    end else if (!lut_ready) begin
      if (ptr_load || wr_strobe) wr_err <= 1'b1;
    end else begin
      if (ptr_load) begin
        ptr         <= ptr_adr;
        ptr_wrapped <= 1'b0;
      end
      if (wr_strobe) begin
        ptr <= wr_base + 1'b1;
        if (wr_base == LAST_ADR) ptr_wrapped <= 1'b1;
      end
    end
  end

  gem_csc_lut_ram u_ram (
    .clock  (clock),
    .we     (ram_we),
    .wr_adr (ram_wr_adr),
    .wr_dat (ram_wr_dat),
    .rd_adr (rd_adr),
    .rd_dat (rd_dat)
  );

  // Lookup port gi: CLCT gi/2, GEM layer gi%2.
  generate
    for (genvar gi = 0; gi < N_LOOKUP; gi++) begin : g_lookup
      localparam gem_layer_t LAYER = (gi % 2 == 0) ? LAYER_A : LAYER_B;
      if (gi < 2) begin : g_clct0
        assign rd_adr[gi] = lut_adr(isME1a0, even, LAYER, clct0_bend);
      end else begin : g_clct1
        assign rd_adr[gi] = lut_adr(isME1a1, even, LAYER, clct1_bend);
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          offset[gi] <= '0;
        end else begin
          offset[gi] <= lut_ready ? rd_dat[gi] : '0;
        end
      end
    end
  endgenerate

  assign rd_adr[RB_PORT] = ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= lut_ready ? rd_dat[RB_PORT] : '0;
    end
  end

  assign clct0_gemA_offset = offset[0];
  assign clct0_gemB_offset = offset[1];
  assign clct1_gemA_offset = offset[2];
  assign clct1_gemB_offset = offset[3];

endmodule
